// File: rtl/ao222_stim_pkg.sv
// Shared definitions for the AO222 exhaustive stimulus generator:
// FSM states, MODE encodings, sweep length and LFSR constants.
package ao222_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam int         NUM_VEC   = 64;
  localparam logic [5:0] LAST_IDX  = 6'(NUM_VEC - 1);

  // Fibonacci LFSR x^6 + x^5 + 1: feedback from bits 5 and 4, shift left.
  localparam logic [5:0] LFSR_SEED = 6'b000001;
  localparam logic [5:0] LFSR_TAPS = 6'b110000;

  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {s[4:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [5:0] bin2gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reference AO222 function; vec[0] is IN1 ... vec[5] is IN6.
  function automatic logic ao222_ref(input logic [5:0] v);
    return (v[0] & v[1]) | (v[2] & v[3]) | (v[4] & v[5]);
  endfunction

endpackage

// File: rtl/ao222_vec_seq.sv
// Vector sequencer: index, LFSR and mode mux. Holds the currently applied
// 6-bit vector in a register so the cell inputs come straight from flops.
module ao222_vec_seq
  import ao222_stim_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       adv_i,
  input  logic       stop_i,
  output logic [5:0] vec_o,
  output logic       last_o
);

  logic [1:0] mode_q, mode_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [5:0] vec_q, vec_d;
  logic [5:0] idx_nx_s;
  logic [5:0] lfsr_nx_s;

  // Next index/LFSR/vector: load first vector on start, step on advance, zero on stop.
  always_comb begin
    mode_d    = mode_q;
    idx_d     = idx_q;
    lfsr_d    = lfsr_q;
    vec_d     = vec_q;
    idx_nx_s  = idx_q + 6'd1;
    lfsr_nx_s = lfsr_step(lfsr_q);
    if (start_i) begin
      mode_d = mode_i;
      idx_d  = 6'd0;
      lfsr_d = LFSR_SEED;
      vec_d  = (mode_i == MODE_LFSR) ? LFSR_SEED : 6'd0;
    end else if (stop_i) begin
      idx_d  = 6'd0;
      lfsr_d = LFSR_SEED;
      vec_d  = 6'd0;
    end else if (adv_i) begin
      idx_d  = idx_nx_s;
      lfsr_d = lfsr_nx_s;
      case (mode_q)
        MODE_GRAY: vec_d = bin2gray(idx_nx_s);
        // 63 LFSR states cover every non-zero vector; all-zero closes the sweep.
        MODE_LFSR: vec_d = (idx_nx_s == LAST_IDX) ? 6'd0 : lfsr_nx_s;
        MODE_BIN,
        MODE_RSVD: vec_d = idx_nx_s;
        default:   vec_d = idx_nx_s;
      endcase
    end else begin
      vec_d = vec_q;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q <= MODE_BIN;
      idx_q  <= 6'd0;
      lfsr_q <= LFSR_SEED;
      vec_q  <= 6'd0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
      vec_q  <= vec_d;
    end
  end

  assign vec_o  = vec_q;
  assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/ao222_stim_gen.sv
// Exhaustive stimulus generator / checker for an AO222X1 cell: sweeps all
// 64 input vectors, holds each HOLD cycles, checks Q_DUT at the end of each
// hold and counts mismatches and output transitions.
module ao222_stim_gen
  import ao222_stim_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int TOG_W = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic [1:0]       MODE,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  output logic             IN4,
  output logic             IN5,
  output logic             IN6,
  input  logic             Q_DUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [6:0]       ERR_CNT,
  output logic [TOG_W-1:0] TOG_CNT
);

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
  localparam logic [6:0]       ERR_MAX   = 7'd127;
  localparam logic [TOG_W-1:0] TOG_MAX   = {TOG_W{1'b1}};
  localparam logic [TOG_W-1:0] TOG_ONE   = {{(TOG_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [6:0]       err_q, err_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             qref_q, qref_d;
  logic             first_q, first_d;

  logic             accept_s, sample_s, adv_s, stop_s;
  logic             hold_last_s;
  logic             last_s;
  logic [5:0]       vec_s;

  assign hold_last_s = (hold_q == HOLD_LAST);

  ao222_vec_seq u_seq (
    .clk_i   (CLK),
    .rst_n_i (RSTB),
    .start_i (accept_s),
    .mode_i  (MODE),
    .adv_i   (adv_s),
    .stop_i  (stop_s),
    .vec_o   (vec_s),
    .last_o  (last_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: START only matters in IDLE; leave APPLY after the 64th sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = START ? ST_APPLY : ST_IDLE;
      ST_APPLY:  state_d = (hold_last_s && last_s) ? ST_FINISH : ST_APPLY;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: sequencer strobes and next values of the BUSY/DONE flops.
  always_comb begin
    accept_s = 1'b0;
    sample_s = 1'b0;
    adv_s    = 1'b0;
    stop_s   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept_s = START;
        busy_d   = START;
      end
      ST_APPLY: begin
        sample_s = hold_last_s;
        adv_s    = hold_last_s && !last_s;
        stop_s   = hold_last_s && last_s;
        busy_d   = !(hold_last_s && last_s);
        done_d   = hold_last_s && last_s;
      end
      ST_FINISH: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Hold counter, reference compare and saturating error/toggle counters.
  always_comb begin
    hold_d  = hold_q;
    err_d   = err_q;
    tog_d   = tog_q;
    qref_d  = qref_q;
    first_d = first_q;
    if (accept_s) begin
      hold_d  = 8'd0;
      err_d   = 7'd0;
      tog_d   = {TOG_W{1'b0}};
      first_d = 1'b1;
    end else begin
      if (state_q == ST_APPLY) begin
        hold_d = hold_last_s ? 8'd0 : (hold_q + 8'd1);
      end else begin
        hold_d = 8'd0;
      end
      if (sample_s && (Q_DUT != ao222_ref(vec_s)) && (err_q != ERR_MAX)) begin
        err_d = err_q + 7'd1;
      end else begin
        err_d = err_q;
      end
      // First BUSY cycle only captures the reference level, later ones count edges.
      if (busy_q) begin
        qref_d = Q_DUT;
        if (first_q) begin
          first_d = 1'b0;
        end else if ((Q_DUT != qref_q) && (tog_q != TOG_MAX)) begin
          tog_d = tog_q + TOG_ONE;
        end else begin
          tog_d = tog_q;
        end
      end else begin
        qref_d = qref_q;
      end
    end
  end

  // Datapath and output flag registers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      hold_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 7'd0;
      tog_q   <= {TOG_W{1'b0}};
      qref_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tog_q   <= tog_d;
      qref_q  <= qref_d;
      first_q <= first_d;
    end
  end

  assign {IN6, IN5, IN4, IN3, IN2, IN1} = vec_s;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR_CNT = err_q;
  assign TOG_CNT = tog_q;

endmodule

// File: tb/tb_ao222_stim_gen.sv
// Directed self-checking bench for ao222_stim_gen. Instance u_dut uses
// HOLD=4, instance u_dut2 uses HOLD=2 for the LFSR / reserved-mode sweeps.
module tb_ao222_stim_gen;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start, start2;
  logic [1:0]  mode, mode2;
  logic [1:0]  q_sel, q_sel2;
  logic        in1, in2, in3, in4, in5, in6;
  logic        j1, j2, j3, j4, j5, j6;
  logic        q_dut, q_dut2;
  logic        busy, done, busy2, done2;
  logic [6:0]  err, err2;
  logic [15:0] tog, tog2;
  logic [5:0]  invec, invec2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign invec  = {in6, in5, in4, in3, in2, in1};
  assign invec2 = {j6, j5, j4, j3, j2, j1};

  // Cell model: 0 = correct AO222, 1 = stuck at 0, 2 = stuck at 1.
  assign q_dut  = (q_sel == 2'd1) ? 1'b0 : (q_sel == 2'd2) ? 1'b1 :
                  ((in1 & in2) | (in3 & in4) | (in5 & in6));
  assign q_dut2 = (q_sel2 == 2'd1) ? 1'b0 : (q_sel2 == 2'd2) ? 1'b1 :
                  ((j1 & j2) | (j3 & j4) | (j5 & j6));

  ao222_stim_gen #(.HOLD(4), .TOG_W(16)) u_dut (
    .CLK(clk), .RSTB(rstb), .START(start), .MODE(mode),
    .IN1(in1), .IN2(in2), .IN3(in3), .IN4(in4), .IN5(in5), .IN6(in6),
    .Q_DUT(q_dut), .BUSY(busy), .DONE(done), .ERR_CNT(err), .TOG_CNT(tog)
  );

  ao222_stim_gen #(.HOLD(2), .TOG_W(16)) u_dut2 (
    .CLK(clk), .RSTB(rstb), .START(start2), .MODE(mode2),
    .IN1(j1), .IN2(j2), .IN3(j3), .IN4(j4), .IN5(j5), .IN6(j6),
    .Q_DUT(q_dut2), .BUSY(busy2), .DONE(done2), .ERR_CNT(err2), .TOG_CNT(tog2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected number of output transitions over a correct-model sweep.
  function automatic int model_toggles(input logic gray);
    int cnt = 0;
    logic [5:0] v;
    logic f, prev;
    prev = 1'b0;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      if (gray) v = v ^ (v >> 1);
      f = (v[0] & v[1]) | (v[2] & v[3]) | (v[4] & v[5]);
      if (i > 0 && f != prev) cnt++;
      prev = f;
    end
    return cnt;
  endfunction

  // Sweep on u_dut (HOLD=4). Optional START re-pulse and early stop cycle.
  task automatic sweep1(input logic [1:0] m, input int restart_at, input int stop_at,
                        output int nbusy, output int done_at, output int vec_bad);
    logic [5:0] idx, expv;
    nbusy = 0; done_at = 0; vec_bad = 0;
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;
    for (int c = 1; c <= 600; c++) begin
      start = (c == restart_at);
      if (busy) begin
        nbusy++;
        idx  = 6'((nbusy - 1) / 4);
        expv = (m == 2'b01) ? (idx ^ (idx >> 1)) : idx;
        if (invec !== expv) vec_bad++;
      end
      if (done) begin
        done_at = c;
        break;
      end
      if (c == stop_at) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // Sweep on u_dut2 (HOLD=2), recording the vector at the start of each hold.
  task automatic sweep2(input logic [1:0] m, output int nbusy, output int done_at,
                        output int nrec, output int distinct, output logic [5:0] firstv,
                        output logic [5:0] lastv, output int bin_bad);
    logic [63:0] seen;
    nbusy = 0; done_at = 0; nrec = 0; distinct = 0; bin_bad = 0;
    firstv = 6'h3f; lastv = 6'h3f; seen = 64'd0;
    mode2 = m; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    mode2 = ~m;
    for (int c = 1; c <= 300; c++) begin
      if (busy2) begin
        nbusy++;
        if (((nbusy - 1) % 2) == 0) begin
          if (nrec == 0) firstv = invec2;
          lastv = invec2;
          seen[invec2] = 1'b1;
          if (invec2 !== 6'((nbusy - 1) / 2)) bin_bad++;
          nrec++;
        end
      end
      if (done2) begin
        done_at = c;
        break;
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 64; i++) if (seen[i]) distinct++;
  endtask

  initial begin
    int nb, da, vb, nr, nd, bb;
    logic [5:0] fv, lv;

    rstb = 1'b0; start = 1'b0; start2 = 1'b0;
    mode = 2'b00; mode2 = 2'b00; q_sel = 2'd0; q_sel2 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in",   32'(invec), 32'd0);
    chk("rst_busy", 32'(busy),  32'd0);
    chk("rst_done", 32'(done),  32'd0);
    chk("rst_err",  32'(err),   32'd0);
    chk("rst_tog",  32'(tog),   32'd0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Binary, correct cell.
    sweep1(2'b00, 0, 0, nb, da, vb);
    chk("bin_busy_cycles", 32'(nb), 32'd256);
    chk("bin_done_cycle",  32'(da), 32'd257);
    chk("bin_vectors",     32'(vb), 32'd0);
    chk("bin_err",         32'(err), 32'd0);
    chk("bin_tog",         32'(tog), 32'(model_toggles(1'b0)));
    chk("fin_in_zero",     32'(invec), 32'd0);
    chk("fin_busy_low",    32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle",  32'(done), 32'd0);
    chk("idle_in_zero",    32'(invec), 32'd0);
    chk("bin_tog_hold",    32'(tog), 32'(model_toggles(1'b0)));

    // Binary, stuck-at-0 cell.
    q_sel = 2'd1;
    sweep1(2'b00, 0, 0, nb, da, vb);
    chk("s0_err", 32'(err), 32'd37);
    chk("s0_tog", 32'(tog), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("s0_err_hold", 32'(err), 32'd37);

    // Gray, stuck-at-1 cell.
    q_sel = 2'd2;
    sweep1(2'b01, 0, 0, nb, da, vb);
    chk("s1_err",     32'(err), 32'd27);
    chk("s1_tog",     32'(tog), 32'd0);
    chk("gray_vecs",  32'(vb),  32'd0);
    chk("gray_done",  32'(da),  32'd257);

    // Gray, correct cell.
    q_sel = 2'd0;
    @(posedge clk); #1;
    sweep1(2'b01, 0, 0, nb, da, vb);
    chk("gray_err", 32'(err), 32'd0);
    chk("gray_tog", 32'(tog), 32'(model_toggles(1'b1)));

    // START re-pulsed at cycle 100 (with MODE changed) is ignored.
    @(posedge clk); #1;
    sweep1(2'b00, 100, 0, nb, da, vb);
    chk("restart_busy", 32'(nb),  32'd256);
    chk("restart_done", 32'(da),  32'd257);
    chk("restart_vecs", 32'(vb),  32'd0);
    chk("restart_err",  32'(err), 32'd0);

    // Reset at cycle 50 of a stuck-at-0 sweep.
    q_sel = 2'd1;
    @(posedge clk); #1;
    sweep1(2'b00, 0, 50, nb, da, vb);
    chk("prerst_busy",   32'(busy), 32'd1);
    chk("prerst_err_nz", 32'(err != 7'd0), 32'd1);
    rstb = 1'b0;
    #1;
    chk("midrst_in",   32'(invec), 32'd0);
    chk("midrst_busy", 32'(busy),  32'd0);
    chk("midrst_done", 32'(done),  32'd0);
    chk("midrst_err",  32'(err),   32'd0);
    chk("midrst_tog",  32'(tog),   32'd0);
    @(posedge clk); #1;
    chk("midrst_nodone", 32'(done), 32'd0);
    rstb = 1'b1;
    q_sel = 2'd0;
    @(posedge clk); #1;
    chk("postrst_nodone", 32'(done), 32'd0);
    sweep1(2'b00, 0, 0, nb, da, vb);
    chk("postrst_busy", 32'(nb),  32'd256);
    chk("postrst_done", 32'(da),  32'd257);
    chk("postrst_vecs", 32'(vb),  32'd0);
    chk("postrst_err",  32'(err), 32'd0);

    // LFSR on HOLD=2 instance, correct cell.
    sweep2(2'b10, nb, da, nr, nd, fv, lv, bb);
    chk("lfsr_busy",     32'(nb),   32'd128);
    chk("lfsr_done",     32'(da),   32'd129);
    chk("lfsr_records",  32'(nr),   32'd64);
    chk("lfsr_distinct", 32'(nd),   32'd64);
    chk("lfsr_first",    32'(fv),   32'd1);
    chk("lfsr_last",     32'(lv),   32'd0);
    chk("lfsr_err",      32'(err2), 32'd0);

    // Reserved MODE=11 behaves as binary.
    q_sel2 = 2'd1;
    @(posedge clk); #1;
    sweep2(2'b11, nb, da, nr, nd, fv, lv, bb);
    chk("rsvd_vecs", 32'(bb),   32'd0);
    chk("rsvd_err",  32'(err2), 32'd37);
    chk("rsvd_done", 32'(da),   32'd129);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ao222_stim_gen.md
AO222_STIM_GEN -- requirements
Module: ao222_stim_gen

Interface
REQ-001 The block SHALL have parameter HOLD, default 4, meaning cycles each input vector is held on IN1..IN6; legal range 2..255.
REQ-002 The block SHALL have parameter TOG_W, default 16, meaning width of the output-toggle counter.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RSTB, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port START, input, 1 bit: request to begin one sweep.
REQ-006 The block SHALL have port MODE, input, 2 bits: sweep order, where 00 is binary, 01 is gray, 10 is LFSR, and 11 is reserved and treated as binary.
REQ-007 The block SHALL have ports IN1..IN6, output, 1 bit each: registered stimulus to the cell under test, with IN1 = vec[0] through IN6 = vec[5].
REQ-008 The block SHALL have port Q_DUT, input, 1 bit: output of the AO222X1 cell under test.
REQ-009 The block SHALL have port BUSY, output, 1 bit: high while a sweep is applying vectors.
REQ-010 The block SHALL have port DONE, output, 1 bit: one-cycle pulse at sweep end.
REQ-011 The block SHALL have port ERR_CNT, output, 7 bits: count of mismatching vectors, saturating at 127.
REQ-012 The block SHALL have port TOG_CNT, output, TOG_W bits: count of Q_DUT transitions during BUSY, saturating at all-ones.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY and FINISH.
REQ-014 In IDLE, the FSM SHALL go to APPLY on START=1; in APPLY, it SHALL go to FINISH after the sample of the 64th vector; FINISH SHALL return to IDLE after 1 cycle.
REQ-015 MODE SHALL be captured on START acceptance and ignored for the rest of the sweep.
REQ-016 START SHALL be ignored outside IDLE.
REQ-017 On acceptance, ERR_CNT, TOG_CNT and the vector index SHALL clear, and the first vector SHALL appear on IN1..IN6 in the next cycle together with BUSY=1.
REQ-018 Binary mode SHALL apply vec = idx for idx 0..63.
REQ-019 Gray mode SHALL apply vec = idx ^ (idx>>1).
REQ-020 LFSR mode SHALL use a 6-bit Fibonacci LFSR, taps x^6+x^5+1, seed 000001, for 63 states, followed by vector 000000 as the 64th, so every vector is applied exactly once.
REQ-021 Each vector SHALL be held exactly HOLD cycles; BUSY SHALL be high for exactly 64*HOLD cycles.
REQ-022 Q_DUT SHALL be sampled in the last cycle of each hold and compared with expected = (IN1&IN2)|(IN3&IN4)|(IN5&IN6) for the vector being driven.
REQ-023 On a sampled mismatch, ERR_CNT SHALL increment by 1 if it is below 127.
REQ-024 Q_DUT SHALL be registered every BUSY cycle; TOG_CNT SHALL increment when the registered value differs from the previous one, except in the first BUSY cycle, which only loads the reference value.
REQ-025 In FINISH, the block SHALL drive BUSY=0 and DONE=1, and return IN1..IN6 to 0.
REQ-026 ERR_CNT and TOG_CNT SHALL hold their values until the next accepted START.
REQ-027 In IDLE, IN1..IN6 SHALL be driven to 0.

Reset
REQ-028 When RSTB=0, the block SHALL immediately force: state IDLE; IN1..IN6, BUSY, DONE, ERR_CNT and TOG_CNT to 0; the LFSR to its seed; the hold counter and vector index to 0.
REQ-029 A reset in mid-sweep SHALL abort the sweep with no DONE pulse, and the first START after RSTB deasserts SHALL begin a complete, clean sweep.

Structure
REQ-030 Package ao222_stim_pkg SHALL hold the state enum, the MODE encodings, NUM_VEC=64, the LFSR seed and the LFSR taps.
REQ-031 Sub-module ao222_vec_seq SHALL contain the vector index, the LFSR and the mode mux, and SHALL produce the current 6-bit vector and a last-vector flag on an advance strobe.
REQ-032 The hold counter, the FSM, the reference compare and the counters SHALL reside in ao222_stim_gen.

Verification
REQ-033 Binary mode, HOLD=4, Q_DUT driven by a correct AO222 model, START pulsed -> BUSY high for 256 cycles, DONE pulse in cycle 257, ERR_CNT=0.
REQ-034 Q_DUT stuck at 0, binary mode -> ERR_CNT=37 and TOG_CNT=0.
REQ-035 Q_DUT stuck at 1, gray mode -> ERR_CNT=27 and TOG_CNT=0.
REQ-036 LFSR mode, HOLD=2 -> the bench records 64 distinct vectors, the last is 000000, and ERR_CNT=0 with a correct model.
REQ-037 START pulsed again at cycle 100 of a sweep -> ignored, and the sweep completes unchanged.
REQ-038 RSTB pulled low at cycle 50 of a sweep -> all outputs 0 immediately with no DONE; after release, START runs a full 64*HOLD sweep.
